// File: rtl/phase_scr_pkg.sv
// Shared definitions for the 4-phase word scrambler and its descrambler.
// Encode and decode maps live side by side so they cannot drift apart.
package phase_scr_pkg;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   // Phase values, named after the transform the transmitter applies.
   localparam logic [1:0] PH_ROT1 = 2'd0;
   localparam logic [1:0] PH_ROT2 = 2'd1;
   localparam logic [1:0] PH_ROT3 = 2'd2;
   localparam logic [1:0] PH_INV  = 2'd3;

   // Transmit-side map: rotate left by 1/2/3 bits, or invert.
   function automatic logic [3:0] scr_encode(input logic [3:0] word, input logic [1:0] phase);
      case (phase)
         PH_ROT1: return {word[2:0], word[3]};
         PH_ROT2: return {word[1:0], word[3:2]};
         PH_ROT3: return {word[0], word[3:1]};
         default: return ~word;
      endcase
   endfunction

   // Receive-side map: exact inverse of scr_encode for the same phase.
   function automatic logic [3:0] scr_decode(input logic [3:0] word, input logic [1:0] phase);
      case (phase)
         PH_ROT1: return {word[0], word[3:1]};
         PH_ROT2: return {word[1:0], word[3:2]};
         PH_ROT3: return {word[2:0], word[3]};
         default: return ~word;
      endcase
   endfunction

endpackage

// File: rtl/phase_unscramble.sv
// Combinational 4-bit unscramble selected by the 2-bit phase.
module phase_unscramble
   import phase_scr_pkg::*;
(
   input  logic [3:0] word,
   input  logic [1:0] phase,
   output logic [3:0] plain
);

   // Pure lookup through the shared decode map.
   assign plain = scr_decode(word, phase);

endmodule

// File: rtl/phase_descrambler.sv
// Receive-side descrambler: hunts for the marker word to align its phase
// counter with the transmitter, then unscrambles accepted words into a
// single registered output stage with valid/ready handshaking.
module phase_descrambler
   import phase_scr_pkg::*;
#(
   parameter logic [3:0] SYNC_WORD = 4'hA,
   parameter int         ERR_W     = 8
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       in_data,
   input  logic             in_valid,
   input  logic             in_sync,
   output logic             in_ready,
   output logic [3:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             locked,
   output logic [ERR_W-1:0] sync_err_cnt
);

   // Marker as it appears on the wire: scrambled at phase 0.
   localparam logic [3:0] MARKER_SCR = scr_encode(SYNC_WORD, PH_ROT1);

   state_t     state;
   state_t     state_nxt;
   logic [1:0] phase;
   logic [3:0] plain;
   logic       accept;
   logic       marker_hit;
   logic       data_hit;

   // Output stage is free when empty or being drained this cycle.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // The raw marker pattern only counts while hunting; once locked it is data
   // unless explicitly flagged with in_sync.
   assign marker_hit = accept && (in_sync || (state == HUNT && in_data == MARKER_SCR));
   assign data_hit   = accept && !marker_hit && (state == LOCKED);

   phase_unscramble u_unscramble (
      .word  (in_data),
      .phase (phase),
      .plain (plain)
   );

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block evaluation order.
      if (!rst_n) state <= HUNT;
      else        state <= state_nxt;
   end

   // Next-state: any accepted marker locks; only reset returns to HUNT.
   always_comb begin
      // NOTE: default assignment first keeps this block free of inferred latches.
      state_nxt = state;
      if (marker_hit) state_nxt = LOCKED;
   end

   // Output decode of the FSM.
   always_comb begin
      locked = (state == LOCKED);
   end

   // Phase counter: realigns on a marker, advances on locked data, frozen otherwise.
   always_ff @(posedge clk) begin
      if (!rst_n)          phase <= PH_ROT1;
      else if (marker_hit) phase <= PH_ROT2;
      else if (data_hit)   phase <= phase + 2'd1;
   end

   // Saturating count of markers that arrive while locked at a nonzero phase.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_err_cnt <= '0;
      end else if (marker_hit && state == LOCKED && phase != PH_ROT1 && sync_err_cnt != '1) begin
         sync_err_cnt <= sync_err_cnt + ERR_W'(1);
      end
   end

   // Output register: load on locked data, clear after a drain with nothing new.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= 4'h0;
      end else if (data_hit) begin
         out_valid <= 1'b1;
         out_data  <= plain;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_phase_descrambler.sv
// Self-checking bench for phase_descrambler: a reference model predicts each
// decoded word into a scoreboard queue, and an independent monitor pops and
// compares whenever the DUT hands a word to the consumer.
module tb_phase_descrambler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] in_data;
   logic       in_valid;
   logic       in_sync;
   logic       in_ready;
   logic [3:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       locked;
   logic [7:0] sync_err_cnt;

   int errors = 0;
   int checks = 0;

   logic [3:0] sb_q[$];
   bit         rand_rdy = 1'b0;

   // Reference model state.
   bit m_locked = 1'b0;
   int m_phase  = 0;
   int m_err    = 0;

   phase_descrambler dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_sync      (in_sync),
      .in_ready     (in_ready),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .locked       (locked),
      .sync_err_cnt (sync_err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transmit scrambling written as plain rotate arithmetic.
   function automatic int ref_encode(input int x, input int ph);
      if (ph == 3) return x ^ 15;
      return ((x << (ph + 1)) | (x >> (3 - ph))) & 15;
   endfunction

   // Plaintext is whichever word the transmitter would scramble into y.
   function automatic int ref_decode(input int y, input int ph);
      for (int x = 0; x < 16; x++)
         if (ref_encode(x, ph) == y) return x;
      return -1;
   endfunction

   // Model reaction to one accepted beat.
   task automatic model_accept(input logic [3:0] d, input logic s);
      bit is_marker;
      is_marker = s || (!m_locked && int'(d) == ref_encode(10, 0));
      if (is_marker) begin
         if (m_locked && m_phase != 0 && m_err < 255) m_err++;
         m_locked = 1'b1;
         m_phase  = 1;
      end else if (m_locked) begin
         sb_q.push_back(4'(ref_decode(int'(d), m_phase)));
         m_phase = (m_phase + 1) % 4;
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         in_sync = 1'($urandom);
         in_data = 4'($urandom);
         @(posedge clk); #1;
         if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   // Offer one word, wait (bounded) for acceptance, then check status outputs.
   task automatic send(input logic [3:0] d, input logic s);
      bit acc = 1'b0;
      in_data  = d;
      in_sync  = s;
      in_valid = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (in_ready) begin
            acc = 1'b1;
            break;
         end
         @(posedge clk); #1;
         if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      end
      if (!acc) begin
         check("accept_timeout", 32'(acc), 32'd1);
         in_valid = 1'b0;
      end else begin
         model_accept(d, s);
         @(posedge clk); #1;
         in_valid = 1'b0;
         in_sync  = 1'b0;
         check("locked", 32'(locked), 32'(m_locked));
         check("sync_err_cnt", 32'(sync_err_cnt), 32'(m_err));
         if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   // Monitor: compares delivered words with the scoreboard and checks that a
   // stalled output stays put.
   initial begin : monitor
      bit         held = 1'b0;
      logic [3:0] held_data = 4'h0;
      logic [3:0] exp;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            held = 1'b0;
         end else begin
            if (held) begin
               check("hold_valid", 32'(out_valid), 32'd1);
               check("hold_data", 32'(out_data), 32'(held_data));
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
               if (sb_q.size() == 0) begin
                  check("out_valid_no_pending", 32'(out_valid), 32'd0);
               end else begin
                  exp = sb_q.pop_front();
                  check("out_data", 32'(out_data), 32'(exp));
               end
            end
            held      = (out_valid === 1'b1) && (out_ready === 1'b0);
            held_data = out_data;
         end
      end
   end

   initial begin : stimulus
      logic [3:0] w;

      // Reset held two cycles with in_valid asserted.
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_sync   = 1'b1;
      in_data   = 4'h5;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_err", 32'(sync_err_cnt), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      in_sync  = 1'b0;
      @(posedge clk); #1;
      check("post_rst_hunt", 32'(locked), 32'd0);

      // Hunt: two non-markers then the raw marker pattern.
      send(4'h3, 1'b0);
      send(4'h7, 1'b0);
      check("hunt_not_locked", 32'(locked), 32'd0);
      send(4'h5, 1'b0);
      check("hunt_locked", 32'(locked), 32'd1);

      // Decode through all four phases.
      send(4'h4, 1'b0);
      send(4'h1, 1'b0);
      send(4'hC, 1'b0);
      send(4'h8, 1'b0);
      idle(1);

      // Backpressure: one word stuck in the output while the next waits.
      out_ready = 1'b0;
      send(4'($urandom), 1'b0);
      in_data  = 4'($urandom);
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("stall_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      send(in_data, 1'b0);

      // Misaligned marker at phase 2.
      for (int i = 0; i < 4 && m_phase != 2; i++) send(4'($urandom), 1'b0);
      send(4'h5, 1'b1);
      check("err_misaligned", 32'(sync_err_cnt), 32'd1);
      send(4'h4, 1'b0);
      idle(1);

      // Marker at phase 0 is not an error.
      for (int i = 0; i < 4 && m_phase != 0; i++) send(4'($urandom), 1'b0);
      send(4'h5, 1'b1);
      check("err_aligned", 32'(sync_err_cnt), 32'd1);
      idle(1);

      // Reset while a word is held under backpressure.
      out_ready = 1'b0;
      send(4'($urandom), 1'b0);
      @(negedge clk);
      check("pre_rst_held", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      sb_q.delete();
      m_locked = 1'b0;
      m_phase  = 0;
      m_err    = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_locked", 32'(locked), 32'd0);
      check("midrst_err", 32'(sync_err_cnt), 32'd0);
      out_ready = 1'b1;
      send(4'h4, 1'b0);
      idle(2);
      send(4'h5, 1'b0);
      send(4'h4, 1'b0);
      idle(1);

      // Randomized traffic with random consumer backpressure.
      rand_rdy = 1'b1;
      for (int i = 0; i < 300; i++) begin
         w = 4'($urandom);
         send(w, ($urandom_range(0, 15) == 0));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end

      // Drain and confirm nothing predicted went missing.
      rand_rdy  = 1'b0;
      out_ready = 1'b1;
      idle(4);
      check("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
